median_window_reader: RTL and testbench
=======================================

// Module: median_window_reader
// PURPOSE
//  Read end of the median-filter line-delay chain. Consumes the three vertically aligned
//  row taps of one raster pixel stream: the current pixel plus the outputs of two
//  IMG_W-deep line delays. Builds a 3x3 neighbourhood with a column shift stage, tracks
//  raster position and emits only windows lying fully inside the image, one cycle after
//  the completing pixel. Feeds the median sorter.
// PARAMETERS
//  IMG_W      12  pixels per line (>=3), equals the depth of the upstream line delays
//  IMG_H      12  lines per frame (>=3)
//  Datawidth  8   bits per pixel
// PORTS
//  CLK        in   1             single clock, rising edge
//  CLR        in   1             synchronous active-low reset (0 = reset, sampled on CLK)
//  WE         in   1             pixel strobe; Row0..Row2 valid and consumed this cycle
//  Row0       in   Datawidth     current pixel (line r)
//  Row1       in   Datawidth     pixel one line earlier (line r-1, same column)
//  Row2       in   Datawidth     pixel two lines earlier (line r-2, same column)
//  Win        out  9*Datawidth   window; tap k=3*i+j at [Datawidth*k +: Datawidth],
//                                i=0 top line (oldest), j=0 leftmost column (oldest)
//  Win_valid  out  1             Win holds a complete in-image window (1-cycle pulse)
//  Ctr_col    out  $clog2(IMG_W) column of the window centre (col-1)
//  Ctr_row    out  $clog2(IMG_H) line of the window centre (row-1)
//  Frame_done out  1             1-cycle pulse: last pixel of the frame was consumed
// BEHAVIOUR
//  - Reset (CLR=0 at a CLK edge): all outputs 0, shift regs 0, col=row=0, state IDLE.
//    Reset mid-frame aborts it with no partial output. The next WE is pixel (0,0).
//  - FSM: IDLE -(WE)-> STREAM; STREAM -(WE at col=IMG_W-1,row=IMG_H-1)-> DONE;
//    DONE -> IDLE unconditionally. A WE during DONE is pixel (0,0) of the next frame and
//    moves to STREAM. The first pixel is accepted in IDLE without loss.
//  - Per accepted pixel: shift column stage left<-right, load {Row2,Row1,Row0} into
//    column j=2. col++, wraps to 0 at IMG_W-1 with row++. row wraps to 0 at IMG_H-1.
//  - WE=0: nothing shifts or counts. Registered outputs hold, except Win_valid=0 and
//    Frame_done=0.
//  - Win_valid <= WE && row>=2 && col>=2 (pre-increment position). Latency 1 cycle.
//    Exactly (IMG_W-2)*(IMG_H-2) pulses per frame. No valid across a line wrap: col 0/1
//    of any line never validates.
//  - Ctr_col/Ctr_row register col-1/row-1 with the same enable as Win_valid.
//  - Frame_done registers in the same cycle as the last Win_valid of the frame.
//  - Win is combinational from the column stage registers, i.e. it updates with
//    Win_valid. Centre tap is k=4.
//  - Row1/Row2 are used as given. Their content during lines 0/1 is irrelevant because
//    those windows are never validated.
//  - No backpressure: the downstream must accept every Win_valid.
// STRUCTURE
//  - Shared package median_pkg: WIN_DIM=3, WIN_TAPS=9, CTR_TAP=4; FSM state encoding
//    {IDLE,STREAM,DONE}; function tap_idx(i,j)=3*i+j.
//  - One sub-module: window_col_shift #(Datawidth): 3 lines x 3 columns of REG stages,
//    enable WE, CLR. It exposes all 9 taps.
//  - Top holds counters, FSM, valid/position/done registers.
// TESTING (IMG_W=IMG_H=4, Datawidth=8; pixel(r,c)=16r+c; taps Row1=pixel(r-1,c),
//          Row2=pixel(r-2,c), 0 when r<1/r<2)
//  1 CLR=0 two cycles with WE toggling -> all outputs 0; first WE after release = (0,0).
//  2 Continuous WE, 16 pixels -> exactly 4 Win_valid. First in the cycle after pixel
//    0x22: Win taps k0..8 = 00,01,02,10,11,12,20,21,22, Ctr=(1,1). Then centres
//    (1,2),(2,1),(2,2).
//  3 Same frame with 1-3 random idle cycles between pixels -> identical 4 windows.
//    Win_valid never high in a cycle after a WE=0 cycle. Outputs hold across gaps.
//  4 Last pixel 0x33 -> Frame_done and Win_valid high in the same cycle, centre (2,2).
//    A back-to-back second frame (WE during DONE) -> 4 identical windows again.
//  5 Assert CLR after pixel 0x12 -> no valid for the aborted frame. A fresh full frame
//    -> 4 correct windows, first centre (1,1).
//  6 Line wrap: pixels 0x30,0x31 -> Win_valid stays 0 despite row>=2. Pixel 0x32 ->
//    valid with centre (2,1).

Source files
------------

// File: rtl/median_pkg.sv
// -----------------------------------------------------------------------------
// median_pkg
// Shared constants, types and helpers for the median-filter window reader.
//   WIN_DIM  : side length of the square neighbourhood (3)
//   WIN_TAPS : number of taps in one window (9)
//   CTR_TAP  : tap index of the window centre (4)
//   state_t  : reader FSM states {IDLE, STREAM, DONE}
//   tap_idx  : flat tap index of line i (0 = oldest) and column j (0 = oldest)
// -----------------------------------------------------------------------------
package median_pkg;

    localparam int WIN_DIM  = 3;
    localparam int WIN_TAPS = WIN_DIM * WIN_DIM;
    localparam int CTR_TAP  = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    function automatic int tap_idx(input int i, input int j);
        return WIN_DIM * i + j;
    endfunction

endpackage

// File: rtl/window_col_shift.sv
// -----------------------------------------------------------------------------
// window_col_shift
// 3 lines x 3 columns of pixel registers forming the neighbourhood. On every
// enabled cycle each line shifts one column towards j=0 and the newest column
// (j=2) is loaded from the three vertically aligned row taps.
// Ports:
//   clk      : clock, rising edge
//   clr_ni   : synchronous active-low clear of all taps
//   en_i     : shift enable (one accepted pixel)
//   row0_i   : current line pixel  -> line i=2 (bottom)
//   row1_i   : one line earlier    -> line i=1
//   row2_i   : two lines earlier   -> line i=0 (top, oldest)
//   taps_o   : all 9 taps, tap k=3*i+j at [Datawidth*k +: Datawidth]
// -----------------------------------------------------------------------------
module window_col_shift
    import median_pkg::*;
#(
    parameter int Datawidth = 8
) (
    input  logic                          clk,
    input  logic                          clr_ni,
    input  logic                          en_i,
    input  logic [Datawidth-1:0]          row0_i,
    input  logic [Datawidth-1:0]          row1_i,
    input  logic [Datawidth-1:0]          row2_i,
    output logic [WIN_TAPS*Datawidth-1:0] taps_o
);

    logic [Datawidth-1:0] line_in [WIN_DIM];
    logic [Datawidth-1:0] tap_q   [WIN_DIM][WIN_DIM];
    logic [Datawidth-1:0] tap_d   [WIN_DIM][WIN_DIM];

    // The oldest line sits at the top of the window.
    assign line_in[0] = row2_i;
    assign line_in[1] = row1_i;
    assign line_in[2] = row0_i;

    for (genvar gi = 0; gi < WIN_DIM; gi++) begin : g_line
        for (genvar gj = 0; gj < WIN_DIM; gj++) begin : g_col
            if (gj == WIN_DIM - 1) begin : g_load
                assign tap_d[gi][gj] = line_in[gi];
            end else begin : g_shift
                assign tap_d[gi][gj] = tap_q[gi][gj+1];
            end
            assign taps_o[Datawidth*tap_idx(gi, gj) +: Datawidth] = tap_q[gi][gj];
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < WIN_DIM; i++) begin
            for (int j = 0; j < WIN_DIM; j++) begin
                if (!clr_ni) begin
                    tap_q[i][j] <= '0;
                end else if (en_i) begin
                    tap_q[i][j] <= tap_d[i][j];
                end
            end
        end
    end

endmodule

// File: rtl/median_window_reader.sv
// -----------------------------------------------------------------------------
// median_window_reader
// Read end of the median-filter line-delay chain. Assembles a 3x3 window from
// three vertically aligned row taps, tracks raster position and flags windows
// that lie completely inside the image, one cycle after the completing pixel.
// Ports:
//   CLK        : clock, rising edge
//   CLR        : synchronous active-low reset
//   WE         : pixel strobe, Row0..Row2 consumed this cycle
//   Row0       : current pixel (line r)
//   Row1       : same column, line r-1
//   Row2       : same column, line r-2
//   Win        : 9-tap window, tap k=3*i+j (i=0 top line, j=0 leftmost column)
//   Win_valid  : 1-cycle pulse, Win is a complete in-image window
//   Ctr_col    : column of the window centre
//   Ctr_row    : line of the window centre
//   Frame_done : 1-cycle pulse, last pixel of the frame consumed
// -----------------------------------------------------------------------------
module median_window_reader
    import median_pkg::*;
#(
    parameter int IMG_W     = 12,
    parameter int IMG_H     = 12,
    parameter int Datawidth = 8
) (
    input  logic                          CLK,
    input  logic                          CLR,
    input  logic                          WE,
    input  logic [Datawidth-1:0]          Row0,
    input  logic [Datawidth-1:0]          Row1,
    input  logic [Datawidth-1:0]          Row2,
    output logic [WIN_TAPS*Datawidth-1:0] Win,
    output logic                          Win_valid,
    output logic [$clog2(IMG_W)-1:0]      Ctr_col,
    output logic [$clog2(IMG_H)-1:0]      Ctr_row,
    output logic                          Frame_done
);

    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);

    state_t          state_q, state_d;
    logic [CW-1:0]   col_q, col_d;
    logic [RW-1:0]   row_q, row_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic [CW-1:0]   ctr_col_q;
    logic [RW-1:0]   ctr_row_q;
    logic            in_window;
    logic            last_pix;

    // Position of the pixel being presented (pre-increment).
    assign in_window = (row_q >= RW'(2)) && (col_q >= CW'(2));
    assign last_pix  = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));

    window_col_shift #(
        .Datawidth (Datawidth)
    ) u_col_shift (
        .clk    (CLK),
        .clr_ni (CLR),
        .en_i   (WE),
        .row0_i (Row0),
        .row1_i (Row1),
        .row2_i (Row2),
        .taps_o (Win)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge CLK) begin
        if (!CLR) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // A strobe in IDLE or DONE is pixel (0,0) of a new frame, so both go to STREAM.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (WE) state_d = ST_STREAM;
            ST_STREAM: if (WE && last_pix) state_d = ST_DONE;
            ST_DONE:   state_d = WE ? ST_STREAM : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Outside STREAM the counters are at (0,0), which can never complete a
    // window, so only STREAM decodes the position.
    always_comb begin
        valid_d = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            ST_STREAM: begin
                valid_d = WE && in_window;
                done_d  = WE && last_pix;
            end
            default: begin
                valid_d = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // ---------------- raster position ----------------
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (WE) begin
            if (col_q == CW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (row_q == RW'(IMG_H - 1)) ? '0 : row_q + RW'(1);
            end else begin
                col_d = col_q + CW'(1);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!CLR) begin
            col_q     <= '0;
            row_q     <= '0;
            valid_q   <= 1'b0;
            done_q    <= 1'b0;
            ctr_col_q <= '0;
            ctr_row_q <= '0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            // Centre is one column left and one line up of the completing pixel.
            if (valid_d) begin
                ctr_col_q <= col_q - CW'(1);
                ctr_row_q <= row_q - RW'(1);
            end
        end
    end

    assign Win_valid  = valid_q;
    assign Frame_done = done_q;
    assign Ctr_col    = ctr_col_q;
    assign Ctr_row    = ctr_row_q;

endmodule

// File: tb/tb_median_window_reader.sv
module tb_median_window_reader;

    localparam int W  = 4;
    localparam int H  = 4;
    localparam int DW = 8;

    logic         clk = 1'b0;
    logic         CLR;
    logic         WE;
    logic [DW-1:0] Row0, Row1, Row2;
    logic [9*DW-1:0] Win;
    logic         Win_valid;
    logic [1:0]   Ctr_col, Ctr_row;
    logic         Frame_done;

    always #5 clk = ~clk;

    median_window_reader #(
        .IMG_W     (W),
        .IMG_H     (H),
        .Datawidth (DW)
    ) dut (
        .CLK        (clk),
        .CLR        (CLR),
        .WE         (WE),
        .Row0       (Row0),
        .Row1       (Row1),
        .Row2       (Row2),
        .Win        (Win),
        .Win_valid  (Win_valid),
        .Ctr_col    (Ctr_col),
        .Ctr_row    (Ctr_row),
        .Frame_done (Frame_done)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    endtask

    // ---------------- image under test ----------------
    logic [7:0] img [0:H-1][0:W-1];

    task automatic set_ramp();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'(16 * r + c);
    endtask

    task automatic set_rand();
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = 8'($urandom);
    endtask

    // ---------------- behavioural model ----------------
    // The window is the last three accepted columns; validity, centre and
    // frame end follow from the pixel's index within the frame.
    int          pix_n;
    logic [23:0] colq[$];
    logic        e_valid, e_done;
    logic [1:0]  e_cc, e_cr;
    logic [71:0] e_win, e_imgwin;
    bit          chk_en = 1'b0;

    initial begin
        pix_n = 0;
        colq = {24'h0, 24'h0, 24'h0};
        e_valid = 1'b0; e_done = 1'b0; e_cc = 2'd0; e_cr = 2'd0;
        e_win = '0; e_imgwin = '0;
        forever begin
            @(posedge clk);
            if (CLR === 1'b0) begin
                pix_n = 0;
                colq = {24'h0, 24'h0, 24'h0};
                e_valid = 1'b0; e_done = 1'b0; e_cc = 2'd0; e_cr = 2'd0;
            end else if (WE === 1'b1) begin
                int r, c;
                r = pix_n / W;
                c = pix_n % W;
                void'(colq.pop_front());
                colq.push_back({Row2, Row1, Row0});
                e_valid = (r >= 2) && (c >= 2);
                e_done  = (pix_n == W * H - 1);
                if (e_valid) begin
                    e_cc = 2'(c - 1);
                    e_cr = 2'(r - 1);
                    for (int i = 0; i < 3; i++)
                        for (int j = 0; j < 3; j++)
                            e_imgwin[8*(3*i+j) +: 8] = img[r-2+i][c-2+j];
                end
                pix_n = (pix_n + 1) % (W * H);
            end else begin
                e_valid = 1'b0;
                e_done  = 1'b0;
            end
            for (int j = 0; j < 3; j++) begin
                logic [23:0] cv;
                cv = colq[j];
                for (int i = 0; i < 3; i++)
                    e_win[8*(3*i+j) +: 8] = cv[8*(2-i) +: 8];
            end
        end
    end

    // ---------------- compare process ----------------
    logic [71:0] cap_win[$];
    logic [71:0] cap_ewin[$];
    int          cap_cc[$];
    int          cap_cr[$];
    logic        cap_done[$];

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                chk("win_valid", 72'(Win_valid), 72'(e_valid));
                chk("frame_done", 72'(Frame_done), 72'(e_done));
                chk("ctr_col", 72'(Ctr_col), 72'(e_cc));
                chk("ctr_row", 72'(Ctr_row), 72'(e_cr));
                chk("win", Win, e_win);
                if (e_valid) chk("win_vs_image", Win, e_imgwin);
                if (Win_valid === 1'b1) begin
                    cap_win.push_back(Win);
                    cap_ewin.push_back(e_win);
                    cap_cc.push_back(int'(Ctr_col));
                    cap_cr.push_back(int'(Ctr_row));
                    cap_done.push_back(Frame_done);
                end
            end
        end
    end

    task automatic clear_caps();
        cap_win.delete(); cap_ewin.delete(); cap_cc.delete();
        cap_cr.delete(); cap_done.delete();
    endtask

    // ---------------- driver ----------------
    task automatic cyc(input logic we, input int r, input int c);
        WE = we;
        if (we) begin
            Row0 = img[r][c];
            Row1 = (r >= 1) ? img[r-1][c] : 8'h00;
            Row2 = (r >= 2) ? img[r-2][c] : 8'h00;
        end else begin
            Row0 = 8'($urandom); Row1 = 8'($urandom); Row2 = 8'($urandom);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_pixels(input int first, input int last, input int gmin, input int gmax);
        for (int n = first; n <= last; n++) begin
            int g;
            g = (gmax == 0) ? 0 : int'($urandom_range(gmax, gmin));
            for (int k = 0; k < g; k++) cyc(1'b0, 0, 0);
            cyc(1'b1, n / W, n % W);
        end
    endtask

    // Hand-computed expectations for one ramp frame (pixel = 16r+c).
    task automatic check_ramp(input string tag, input int base);
        int          ecc[4]  = '{1, 2, 1, 2};
        int          ecr[4]  = '{1, 1, 2, 2};
        logic [7:0]  etap8[4] = '{8'h22, 8'h23, 8'h32, 8'h33};
        logic [71:0] first_win = 72'h22_21_20_12_11_10_02_01_00;
        logic [71:0] w;
        chk({tag, "_first_win"}, cap_win[base], first_win);
        chk({tag, "_model_first_win"}, cap_ewin[base], first_win);
        for (int k = 0; k < 4; k++) begin
            w = cap_win[base+k];
            chk($sformatf("%s_ctr_col%0d", tag, k), 72'(cap_cc[base+k]), 72'(ecc[k]));
            chk($sformatf("%s_ctr_row%0d", tag, k), 72'(cap_cr[base+k]), 72'(ecr[k]));
            chk($sformatf("%s_tap8_%0d", tag, k), 72'(w[71:64]), 72'(etap8[k]));
            chk($sformatf("%s_centre%0d", tag, k), 72'(w[39:32]),
                72'(16 * ecr[k] + ecc[k]));
            chk($sformatf("%s_done%0d", tag, k), 72'(cap_done[base+k]), 72'(k == 3));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1);
    end

    initial begin
        CLR = 1'b0; WE = 1'b0; Row0 = '0; Row1 = '0; Row2 = '0;
        set_ramp();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;

        // 1: reset held with WE toggling
        cyc(1'b1, 2, 2);
        cyc(1'b0, 0, 0);
        chk("rst_valid", 72'(Win_valid), 72'd0);
        chk("rst_win", Win, 72'd0);
        chk("rst_done", 72'(Frame_done), 72'd0);
        chk("rst_ctr", 72'({Ctr_row, Ctr_col}), 72'd0);
        CLR = 1'b1;

        // 2: continuous frame
        clear_caps();
        run_pixels(0, 15, 0, 0);
        cyc(1'b0, 0, 0);
        chk("t2_count", 72'(cap_win.size()), 72'd4);
        if (cap_win.size() == 4) check_ramp("t2", 0);

        // 3: same frame with 1-3 idle cycles between pixels
        clear_caps();
        run_pixels(0, 15, 1, 3);
        cyc(1'b0, 0, 0);
        chk("t3_count", 72'(cap_win.size()), 72'd4);
        if (cap_win.size() == 4) check_ramp("t3", 0);

        // 4: back-to-back frames (next frame's first pixel during DONE)
        clear_caps();
        run_pixels(0, 15, 0, 0);
        run_pixels(0, 15, 0, 0);
        cyc(1'b0, 0, 0);
        chk("t4_count", 72'(cap_win.size()), 72'd8);
        if (cap_win.size() == 8) begin
            check_ramp("t4a", 0);
            check_ramp("t4b", 4);
        end

        // 5: abort after pixel 0x12, then a fresh frame
        clear_caps();
        run_pixels(0, 6, 0, 0);
        CLR = 1'b0;
        cyc(1'b0, 0, 0);
        CLR = 1'b1;
        cyc(1'b0, 0, 0);
        chk("t5_abort_count", 72'(cap_win.size()), 72'd0);
        run_pixels(0, 15, 0, 0);
        cyc(1'b0, 0, 0);
        chk("t5_count", 72'(cap_win.size()), 72'd4);
        if (cap_win.size() == 4) check_ramp("t5", 0);

        // 6: line wrap into row 3
        clear_caps();
        run_pixels(0, 13, 0, 0);
        cyc(1'b0, 0, 0);
        chk("t6_wrap_count", 72'(cap_win.size()), 72'd2);
        cyc(1'b1, 3, 2);
        cyc(1'b0, 0, 0);
        chk("t6_count", 72'(cap_win.size()), 72'd3);
        if (cap_win.size() == 3)
            chk("t6_ctr", 72'({cap_cr[2][1:0], cap_cc[2][1:0]}), 72'({2'd2, 2'd1}));
        cyc(1'b1, 3, 3);
        cyc(1'b0, 0, 0);

        // Randomized frames, random gaps, occasional mid-frame abort
        for (int f = 0; f < 8; f++) begin
            int abort_at;
            set_rand();
            clear_caps();
            abort_at = ($urandom_range(2, 0) == 0) ? int'($urandom_range(14, 1)) : -1;
            if (abort_at >= 0) begin
                run_pixels(0, abort_at, 0, 3);
                CLR = 1'b0;
                cyc(1'b0, 0, 0);
                CLR = 1'b1;
            end else begin
                run_pixels(0, 15, 0, 3);
                cyc(1'b0, 0, 0);
                chk($sformatf("rand%0d_count", f), 72'(cap_win.size()), 72'd4);
            end
        end

        repeat (3) cyc(1'b0, 0, 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
